// File: rtl/console_pkg.sv
`default_nettype none
// console_pkg: constants, encodings and cursor wrap helpers for text_console_writer (rev 1.0).
// Optional feature macro: CONSOLE_TAB_EN.
package console_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 60;

  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_TAB = 8'h09;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_FF  = 8'h0C;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_SP  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
`ifdef CONSOLE_TAB_EN
    ST_CLEAR = 2'd2,
    ST_TAB   = 2'd3
`else
    ST_CLEAR = 2'd2
`endif
  } state_e;

  typedef enum logic [2:0] {
    CUR_NOP  = 3'd0,
    CUR_ADV  = 3'd1,
    CUR_RET  = 3'd2,
    CUR_NL   = 3'd3,
    CUR_HOME = 3'd4
  } cur_cmd_e;

  // Packed so that a position is directly the 13-bit VRAM address {y, x}.
  typedef struct packed {
    logic [5:0] y;
    logic [6:0] x;
  } pos_t;

  function automatic pos_t pos_advance(input pos_t p, input int cols, input int rows);
    pos_t n;
    n = p;
    if (p.x == 7'(cols - 1)) begin
      n.x = '0;
      n.y = (p.y == 6'(rows - 1)) ? 6'd0 : p.y + 6'd1;
    end else begin
      n.x = p.x + 7'd1;
    end
    return n;
  endfunction

  function automatic pos_t pos_retreat(input pos_t p, input int cols, input int rows);
    pos_t n;
    n = p;
    if (p.x == 7'd0) begin
      n.x = 7'(cols - 1);
      n.y = (p.y == 6'd0) ? 6'(rows - 1) : p.y - 6'd1;
    end else begin
      n.x = p.x - 7'd1;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/console_cursor.sv
`default_nettype none
// console_cursor: cursor position register with advance/retreat/newline/home and wrap rules (rev 1.0).
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  cur_cmd_e cmd_i,
  output pos_t     pos_o
);

  pos_t pos_q;
  pos_t pos_d;

  always_comb begin
    pos_d = pos_q;
    case (cmd_i)
      CUR_ADV:  pos_d = pos_advance(pos_q, COLS, ROWS);
      CUR_RET:  pos_d = pos_retreat(pos_q, COLS, ROWS);
      CUR_NL: begin
        pos_d.x = '0;
        pos_d.y = (pos_q.y == 6'(ROWS - 1)) ? 6'd0 : pos_q.y + 6'd1;
      end
      CUR_HOME: pos_d = '0;
      default:  pos_d = pos_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule
`default_nettype wire

// File: rtl/text_console_writer.sv
`default_nettype none
// text_console_writer: character stream to char-VRAM write front end (rev 1.0).
// Optional feature macro: CONSOLE_TAB_EN (tab expansion to the next 8-column stop).
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = ASC_SP
) (
  input  logic        CLK_100MHz,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        vram_wea,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y,
  output logic        busy
);

  state_e     state_q;
  logic       vram_wea_q;
  pos_t       vram_addr_q;
  logic [7:0] vram_data_q;
  pos_t       scan_q;
  logic       adv_after_q;

  pos_t       cur_pos;
  cur_cmd_e   cur_cmd;
  logic       accept;
  logic       at_origin;
  logic       clear_last;

  assign accept     = char_valid && (state_q == ST_IDLE);
  assign at_origin  = (cur_pos == '0);
  assign clear_last = (vram_addr_q == {6'(ROWS - 1), 7'(COLS - 1)});

  always_comb begin
    cur_cmd = CUR_NOP;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (char_data == ASC_LF || char_data == ASC_CR) begin
            cur_cmd = CUR_NL;
          end else if (char_data == ASC_BS && !at_origin) begin
            cur_cmd = CUR_RET;
          end
        end
      end
      ST_WRITE: cur_cmd = adv_after_q ? CUR_ADV : CUR_NOP;
      ST_CLEAR: cur_cmd = clear_last ? CUR_HOME : CUR_NOP;
`ifdef CONSOLE_TAB_EN
      ST_TAB:   cur_cmd = CUR_ADV;
`endif
      default:  cur_cmd = CUR_NOP;
    endcase
  end

  console_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk_i  (CLK_100MHz),
    .rst_ni (rst_n),
    .cmd_i  (cur_cmd),
    .pos_o  (cur_pos)
  );

  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vram_wea_q  <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
      scan_q      <= '0;
      adv_after_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          vram_wea_q <= 1'b0;
          if (accept) begin
            if (char_data >= ASC_SP) begin
              state_q     <= ST_WRITE;
              vram_wea_q  <= 1'b1;
              vram_addr_q <= cur_pos;
              vram_data_q <= char_data;
              adv_after_q <= 1'b1;
            end else if (char_data == ASC_BS && !at_origin) begin
              // Cursor retreats this edge and stays on the erased cell.
              state_q     <= ST_WRITE;
              vram_wea_q  <= 1'b1;
              vram_addr_q <= pos_retreat(cur_pos, COLS, ROWS);
              vram_data_q <= BLANK;
              adv_after_q <= 1'b0;
            end else if (char_data == ASC_FF) begin
              state_q     <= ST_CLEAR;
              vram_wea_q  <= 1'b1;
              vram_addr_q <= '0;
              vram_data_q <= BLANK;
              scan_q      <= '{y: 6'd0, x: 7'd1};
            end
`ifdef CONSOLE_TAB_EN
            else if (char_data == ASC_TAB) begin
              state_q     <= ST_TAB;
              vram_wea_q  <= 1'b1;
              vram_addr_q <= cur_pos;
              vram_data_q <= BLANK;
            end
`endif
          end
        end
        ST_WRITE: begin
          state_q    <= ST_IDLE;
          vram_wea_q <= 1'b0;
        end
        ST_CLEAR: begin
          if (clear_last) begin
            state_q    <= ST_IDLE;
            vram_wea_q <= 1'b0;
          end else begin
            vram_wea_q  <= 1'b1;
            vram_addr_q <= scan_q;
            scan_q      <= pos_advance(scan_q, COLS, ROWS);
          end
        end
`ifdef CONSOLE_TAB_EN
        ST_TAB: begin
          // The cursor advances this edge; stop once it lands on a tab stop.
          if (pos_advance(cur_pos, COLS, ROWS).x[2:0] == 3'd0) begin
            state_q    <= ST_IDLE;
            vram_wea_q <= 1'b0;
          end else begin
            vram_wea_q  <= 1'b1;
            vram_addr_q <= pos_advance(cur_pos, COLS, ROWS);
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          vram_wea_q <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready = (state_q == ST_IDLE);
`ifdef CONSOLE_TAB_EN
  assign busy       = (state_q == ST_CLEAR) || (state_q == ST_TAB);
`else
  assign busy       = (state_q == ST_CLEAR);
`endif
  assign vram_wea   = vram_wea_q;
  assign vram_addr  = vram_addr_q;
  assign vram_data  = vram_data_q;
  assign cursor_x   = cur_pos.x;
  assign cursor_y   = cur_pos.y;

endmodule
`default_nettype wire

// File: tb/tb_text_console_writer.sv
`default_nettype none
// tb_text_console_writer: randomized + directed scoreboard bench for text_console_writer.
module tb_text_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic        clk;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        vram_wea;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int mx = 0;
  int my = 0;
  logic [20:0] exp_q[$];

  text_console_writer dut (
    .CLK_100MHz (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .vram_wea   (vram_wea),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: cursor as plain integers, cell address = row*128 + column.
  task automatic m_push(input int x, input int y, input int d);
    exp_q.push_back(21'((y * 128 + x) * 256 + d));
  endtask

  task automatic m_adv();
    mx++;
    if (mx == COLS) begin
      mx = 0;
      my = (my + 1) % ROWS;
    end
  endtask

  task automatic model(input int c);
    if (c == 10 || c == 13) begin
      mx = 0;
      my = (my + 1) % ROWS;
    end else if (c == 8) begin
      if (mx != 0 || my != 0) begin
        if (mx == 0) begin mx = COLS - 1; my = my - 1; end
        else mx = mx - 1;
        m_push(mx, my, 32);
      end
    end else if (c == 12) begin
      for (int yy = 0; yy < ROWS; yy++)
        for (int xx = 0; xx < COLS; xx++)
          m_push(xx, yy, 32);
      mx = 0;
      my = 0;
    end else if (c == 9) begin
`ifdef CONSOLE_TAB_EN
      do begin
        m_push(mx, my, 32);
        m_adv();
      end while (mx % 8 != 0);
`endif
    end else if (c >= 32) begin
      m_push(mx, my, c);
      m_adv();
    end
  endtask

  // Monitor: every VRAM write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && vram_wea) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", vram_addr, vram_data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({vram_addr, vram_data} != e || vram_addr[6:0] >= 7'd80) begin
          bad++;
          $display("FAIL vram_write actual=%0h/%0h required=%0h/%0h",
                   vram_addr, vram_data, e[20:8], e[7:0]);
        end
      end
    end
  end

  task automatic send(input int c);
    int n;
    n = 0;
    while (!char_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      model(c);
      char_valid = 1'b1;
      char_data  = 8'(c);
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      char_data  = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(char_ready && exp_q.size() == 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, int'(char_ready && exp_q.size() == 0), 1);
    check({name, "_cursor"}, {cursor_y, cursor_x}, my * 128 + mx);
  endtask

  initial begin
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    #23;
    check("rst_ready", int'(char_ready), 1);
    check("rst_wea", int'(vram_wea), 0);
    check("rst_addr_data", {vram_addr, vram_data}, 0);
    check("rst_cursor_busy", {cursor_y, cursor_x, busy}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 'A' with handshake pattern, then 'B'.
    send(8'h41);
    check("A_ready_low", int'(char_ready), 0);
    @(posedge clk);
    #1;
    check("A_ready_high", int'(char_ready), 1);
    send(8'h42);
    wait_idle("AB");
    check("AB_cursor_x", int'(cursor_x), 2);

    // Walk to (79,59) and write 'Z' at the last cell.
    for (int i = 0; i < 59; i++) send(8'h0D);
    for (int i = 0; i < 79; i++) send(8'h61 + (i % 26));
    wait_idle("to_corner");
    check("corner_pos", {cursor_y, cursor_x}, 13'h1DCF);
    send(8'h5A);
    wait_idle("Z_wrap");

    // Backspace at origin is a no-op, then across a row boundary.
    send(8'h08);
    wait_idle("bs_origin");
    for (int i = 0; i < 5; i++) send(8'h0A);
    send(8'h08);
    wait_idle("bs_row");

    // Clear from (10,10).
    for (int i = 0; i < 6; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h30 + i);
    wait_idle("to_10_10");
    send(8'h0C);
    check("clear_busy", int'(busy), 1);
    wait_idle("clear");
    check("clear_busy_end", int'(busy), 0);

    // Carriage return and a dropped code.
    for (int i = 0; i < 2; i++) send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h2B);
    send(8'h0D);
    wait_idle("cr");
    send(8'h07);
    wait_idle("bel_drop");

    // Tab from (3,0).
    for (int i = 0; i < 57; i++) send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h2D);
    send(8'h09);
    wait_idle("tab");

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      int r;
      int c;
      r = int'($urandom_range(0, 99));
      if (r < 70)      c = int'($urandom_range(32, 255));
      else if (r < 80) c = (r % 2 == 0) ? 10 : 13;
      else if (r < 88) c = 8;
      else if (r < 93) c = 9;
      else begin
        c = int'($urandom_range(0, 31));
        if (c == 12) c = 7;
      end
      send(c);
      if (i % 25 == 24) wait_idle("rand");
    end
    wait_idle("rand_end");

    // Reset in the middle of a clear aborts immediately.
    send(8'h0C);
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wea", int'(vram_wea), 0);
    check("abort_ready", int'(char_ready), 1);
    check("abort_cursor_busy", {cursor_y, cursor_x, busy}, 0);
    exp_q.delete();
    mx = 0;
    my = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    wait_idle("after_abort");

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end for the 80x60 text-mode VGA path: accepts one 8-bit character per handshake (from the PS/2 keyboard buffer or CPU), maintains a cursor, and emits single-cycle write transactions into the character VRAM. It drives the VRAM write port (`addr`, `data`, `wea`) directly upstream of the char VRAM/glyph ROM display stage. Control codes are interpreted as newline, backspace, form feed (clear) and, optionally, tab.

## Interface
- `COLS`, 80: visible columns; cursor x range 0..COLS-1.
- `ROWS`, 60: visible rows; cursor y range 0..ROWS-1.
- `BLANK`, 8'h20: code written for erase, clear and tab fill.
- `CLK_100MHz`  in  1: system clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `char_valid`  in  1: `char_data` holds a character.
- `char_data`  in  8: character code.
- `char_ready`  out  1: block can accept; transfer when `char_valid && char_ready`.
- `vram_wea`  out  1: one-cycle VRAM write strobe.
- `vram_addr`  out  13: `{cursor_y[5:0], cursor_x[6:0]}` of the cell written.
- `vram_data`  out  8: code written.
- `cursor_x`  out  7: current column.
- `cursor_y`  out  6: current row.
- `busy`  out  1: high in CLEAR or TAB.

## Operation
- States: IDLE, WRITE, CLEAR, TAB. `char_ready` = (state == IDLE).
- Accept in IDLE, decode `char_data`:
  - 0x0A or 0x0D: x←0, y←y+1 (ROWS-1 wraps to 0); no write; stay IDLE.
  - 0x08: at (0,0) no-op. Else move back one cell (x=0 → x=COLS-1, y−1), go WRITE with `BLANK`; cursor stays on the erased cell.
  - 0x0C: go CLEAR.
  - 0x09: TAB if `CONSOLE_TAB_EN`, else dropped.
  - other 0x00–0x1F: dropped, no write.
  - 0x20–0xFF: go WRITE with the code; after the write advance.
- Advance: x+1; at x=COLS-1 → x=0, y+1; at (COLS-1, ROWS-1) → (0,0). No scrolling.
- WRITE: `vram_wea`=1 for one cycle, addr/data valid in that cycle; cursor updates at the end of the cycle; → IDLE.
- CLEAR: scan cells row-major (0,0)..(COLS-1,ROWS-1), one `BLANK` write per cycle (COLS*ROWS = 4800 writes); then cursor (0,0), → IDLE.
- TAB: write `BLANK` at cursor and advance every cycle until the advanced x is a multiple of 8 (at least one write); row wrap rules as for advance; → IDLE.
- Column addresses 80..127 are never written.

## Timing
- Reset (async): state IDLE, `char_ready`=1, `vram_wea`=0, `vram_addr`=0, `vram_data`=0, cursor (0,0), `busy`=0. Reset mid-CLEAR/TAB aborts immediately, with no further writes.
- Printable/backspace: accept at edge T; `vram_wea` high in cycle T+1; `char_ready` low in T+1, high again in T+2. Throughput: one character per 2 cycles.
- Newline/dropped codes: consumed in 1 cycle; `char_ready` stays high.
- Clear: 4800 write cycles after acceptance; `char_ready` returns the cycle after the last write.
- `char_valid` while not ready: held by source; no data sampled.
- Outputs are registered; `vram_addr`/`vram_data` are don't-care when `vram_wea`=0.

## Configuration
- `CONSOLE_TAB_EN` defined: 0x09 enters TAB (expand to the next 8-column stop).
- Not defined: TAB state and its logic are absent; 0x09 is consumed and dropped like other control codes.

## Structure
- Package `console_pkg`: `COLS`/`ROWS` defaults, ASCII constants (`ASC_BS`, `ASC_TAB`, `ASC_LF`, `ASC_CR`, `ASC_FF`, `ASC_SP`), state enum.
- One sub-module, `console_cursor`: holds x/y and implements advance, backspace-retreat, newline, home, and the wrap rules. The top-level FSM drives its command inputs.

## Test plan
- Reset, send 'A','B' → writes (addr 0x0000, 0x41), (addr 0x0001, 0x42); cursor (2,0); `char_ready` pattern 1,0,1 per character.
- Cursor at (79,59), send 'Z' → write at `{59,79}` = 0x1DCF, data 0x5A; cursor (0,0).
- Cursor (0,5), send 0x08 → write `BLANK` at `{4,79}`, cursor (79,4); at (0,0), 0x08 → no write.
- Send 0x0C at cursor (10,10) → exactly 4800 writes of 0x20, first addr 0x0000, last 0x1DCF, no column ≥80; cursor (0,0); assert `rst_n` low mid-clear → `vram_wea` drops at once.
- Cursor (3,2), send 0x0D → cursor (0,3), no write; 0x07 → dropped, no write.
- With `CONSOLE_TAB_EN`, cursor (3,0), send 0x09 → 5 blank writes at x=3..7, cursor (8,0); without the macro → no write, cursor unchanged.
